rob_commit_ctrl: RTL and testbench
==================================

# rob_commit_ctrl

Commit-stage sequencer for the reorder buffer. It drives the ROB's commit and erase ports, and retires head entries in order into the register file. When the head entry carries an exception, it flushes the whole ROB and raises a precise exception request with a corrected EPC. It also arbitrates branch-mispredict erase requests from the branch unit against exception flushes.

## Interface
Parameters:
- ROB_ADDR_WIDTH, 4, ROB index width (2^N entries)
- EXC_TYPE_WIDTH, 8, exception-type field width; zero means no exception
- HOLD_CYCLES, 2, cycles commit stays blocked after an exception flush (front-end redirect)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- can_commit  in  1  ROB head entry is valid and completed
- head_reg_write_en_in  in  1  head entry writes a register
- head_reg_write_addr_in  in  5  destination register
- head_reg_write_data_in  in  32  result
- head_exception_type_in  in  EXC_TYPE_WIDTH  head exception code
- head_is_delayslot_in  in  1  head is a delay-slot instruction
- head_pc_in  in  32  head PC
- stall  in  1  downstream busy; blocks commit
- br_flush_en  in  1  mispredict flush request
- br_flush_from_addr  in  ROB_ADDR_WIDTH  first wrong-path ROB index
- commit_en  out  1  pop ROB head this cycle (combinational)
- erase_en  out  1  ROB erase strobe (combinational)
- erase_from_addr  out  ROB_ADDR_WIDTH  first index to erase
- rf_write_en  out  1  register-file write (registered)
- rf_write_addr  out  5
- rf_write_data  out  32
- exc_en  out  1  exception request pulse (registered)
- exc_type  out  EXC_TYPE_WIDTH
- exc_epc  out  32  EPC
- exc_is_delayslot  out  1  BD bit
- busy  out  1  high outside RUN
- commit_count  out  32  retired-instruction counter

## Operation
- States: RUN, FLUSH, HOLD.
- head_ptr (ROB_ADDR_WIDTH bits) is an internal copy of the ROB head.
  - Increments on every commit_en, wrapping modulo 2^ROB_ADDR_WIDTH.
  - Resets to 0 on exception flush.
- RUN:
  - exc_hit = can_commit && head_exception_type_in != 0.
  - commit_en = can_commit && !stall && !exc_hit.
  - On exc_hit && !stall: commit_en=0, erase_en=1, erase_from_addr=head_ptr, latch exc fields, go to FLUSH.
  - Else if br_flush_en: erase_en=1, erase_from_addr=br_flush_from_addr. A commit may proceed in the same cycle. br_flush_from_addr==head_ptr with commit_en=1 is illegal; the bench flags it with an assertion.
  - Exception beats mispredict: br_flush_en is ignored in the exc_hit cycle.
- EPC and BD bit: exc_epc = head_pc_in − 4 if head_is_delayslot_in, else head_pc_in; exc_is_delayslot = head_is_delayslot_in.
- FLUSH (1 cycle):
  - exc_en=1 with the latched fields; head_ptr←0; commit_en=0; erase_en=0.
  - Go to HOLD with hold counter = HOLD_CYCLES.
- HOLD:
  - commit_en=0; br_flush_en is ignored.
  - Counter decrements each cycle; at 0 return to RUN. HOLD_CYCLES=0 goes FLUSH→RUN directly.
- commit_count increments on each commit_en (exception instructions are not counted) and wraps at 2^32.
- Reset mid-flush returns to RUN immediately; all state is cleared.

## Timing
- Reset values:
  - All outputs 0; state RUN; head_ptr 0; commit_count 0; busy 0.
- Latency:
  - commit_en and erase_en are combinational from inputs in the same cycle.
  - rf_write_* is registered: it is valid the cycle after commit_en, with rf_write_en = head_reg_write_en_in captured at commit.
  - exc_en rises one cycle after the erase_en of an exception flush and lasts exactly 1 cycle.
- Commit throughput: 1 per cycle while can_commit and !stall.
- stall high: commit_en=0, no state change. An exception at the head waits until stall drops.
- busy = (state != RUN).

## Structure
- Shared package/header (rob.v): ROB_ADDR_WIDTH, EXC_TYPE_WIDTH, EXC_NONE=0, state encodings RUN=0, FLUSH=1, HOLD=2.
- One natural sub-module, rob_head_tracker: head_ptr plus commit_count, with inc/clear inputs.

## Test plan
- Reset, then can_commit=1 for 3 cycles, exc=0, pc 0xbfc00000/04/08 → commit_en high 3 cycles; rf_write_en high the following 3 cycles; commit_count=3; head_ptr=3.
- Head exc_type=0x04, pc=0xbfc00010, delayslot=1 → erase_en=1 with erase_from_addr=head_ptr, commit_en=0; next cycle exc_en=1, exc_epc=0xbfc0000c, exc_is_delayslot=1; busy for 1+HOLD_CYCLES cycles.
- br_flush_en with from_addr=2, head_ptr=0, can_commit=1 → commit_en=1 and erase_en=1 with erase_from_addr=2 in the same cycle.
- Exception at head and br_flush_en (from_addr=5) in the same cycle → erase_from_addr=head_ptr; branch request dropped.
- stall=1 with can_commit=1 for 4 cycles → no commit_en, no rf write; release → commit resumes the next cycle.
- 17 consecutive commits with ROB_ADDR_WIDTH=4 → head_ptr wraps 15→0→1. Reset asserted during HOLD → state RUN and all outputs 0 on the next edge.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared definitions for the ROB commit sequencer: default widths,
// the "no exception" code, FSM state encodings and the EPC helper.
package rob_commit_ctrl_pkg;

    localparam int ROB_ADDR_WIDTH = 4;
    localparam int EXC_TYPE_WIDTH = 8;
    localparam int HOLD_CYCLES    = 2;
    localparam int EXC_NONE       = 0;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // A delay-slot instruction reports the PC of its branch as EPC.
    function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic is_ds);
        return is_ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/rob_commit_ctrl_head_tracker.sv
// Internal copy of the ROB head pointer plus the retired-instruction counter.
module rob_commit_ctrl_head_tracker
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ADDR_W = rob_commit_ctrl_pkg::ROB_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_clr,
    output logic [ADDR_W-1:0] o_head_ptr,
    output logic [31:0]       o_commit_count
);

    logic [ADDR_W-1:0] r_head_ptr;
    logic [31:0]       r_commit_count;

    // Head pointer follows commits (wrapping naturally) and returns to 0 on flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head_ptr <= '0;
        end else if (i_clr) begin
            r_head_ptr <= '0;
        end else if (i_inc) begin
            r_head_ptr <= r_head_ptr + 1'b1;
        end
    end

    // Retired-instruction counter; exceptions never pulse i_inc so are not counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_commit_count <= '0;
        end else if (i_inc) begin
            r_commit_count <= r_commit_count + 32'd1;
        end
    end

    assign o_head_ptr     = r_head_ptr;
    assign o_commit_count = r_commit_count;

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB commit-stage sequencer: in-order retirement into the register file,
// precise exception flush with EPC correction, and mispredict erase arbitration.
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ROB_ADDR_WIDTH = rob_commit_ctrl_pkg::ROB_ADDR_WIDTH,
    parameter int EXC_TYPE_WIDTH = rob_commit_ctrl_pkg::EXC_TYPE_WIDTH,
    parameter int HOLD_CYCLES    = rob_commit_ctrl_pkg::HOLD_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      can_commit,
    input  logic                      head_reg_write_en_in,
    input  logic [4:0]                head_reg_write_addr_in,
    input  logic [31:0]               head_reg_write_data_in,
    input  logic [EXC_TYPE_WIDTH-1:0] head_exception_type_in,
    input  logic                      head_is_delayslot_in,
    input  logic [31:0]               head_pc_in,
    input  logic                      stall,
    input  logic                      br_flush_en,
    input  logic [ROB_ADDR_WIDTH-1:0] br_flush_from_addr,
    output logic                      commit_en,
    output logic                      erase_en,
    output logic [ROB_ADDR_WIDTH-1:0] erase_from_addr,
    output logic                      rf_write_en,
    output logic [4:0]                rf_write_addr,
    output logic [31:0]               rf_write_data,
    output logic                      exc_en,
    output logic [EXC_TYPE_WIDTH-1:0] exc_type,
    output logic [31:0]               exc_epc,
    output logic                      exc_is_delayslot,
    output logic                      busy,
    output logic [31:0]               commit_count
);

    // Counter must hold HOLD_CYCLES; keep at least one bit when HOLD_CYCLES is 0.
    localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    logic [1:0]                r_state;
    logic [HOLD_W-1:0]         r_hold_cnt;
    logic                      r_rf_we;
    logic [4:0]                r_rf_addr;
    logic [31:0]               r_rf_data;
    logic                      r_exc_en;
    logic [EXC_TYPE_WIDTH-1:0] r_exc_type;
    logic [31:0]               r_exc_epc;
    logic                      r_exc_bd;

    logic                      w_in_run;
    logic                      w_exc_hit;
    logic                      w_exc_fire;
    logic                      w_br_take;
    logic                      w_commit;
    logic                      w_erase;
    logic [ROB_ADDR_WIDTH-1:0] w_erase_from;
    logic [ROB_ADDR_WIDTH-1:0] w_head_ptr;
    logic [31:0]               w_commit_count;
    logic [HOLD_W-1:0]         w_hold_next;

    // Commit/erase decode; an exception at the head takes priority over a mispredict.
    always_comb begin
        w_in_run     = rst && (r_state == ST_RUN);
        w_exc_hit    = can_commit && (head_exception_type_in != EXC_TYPE_WIDTH'(EXC_NONE));
        w_exc_fire   = w_in_run && w_exc_hit && !stall;
        w_commit     = w_in_run && can_commit && !stall && !w_exc_hit;
        w_br_take    = w_in_run && br_flush_en && !w_exc_fire;
        w_erase      = w_exc_fire || w_br_take;
        w_erase_from = '0;
        if (w_exc_fire) begin
            w_erase_from = w_head_ptr;
        end else if (w_br_take) begin
            w_erase_from = br_flush_from_addr;
        end
        w_hold_next  = r_hold_cnt - 1'b1;
    end

    // RUN -> FLUSH on exception, FLUSH lasts one cycle, HOLD blocks commit for the redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_exc_fire) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_hold_cnt <= HOLD_W'(HOLD_CYCLES);
                    r_state    <= (HOLD_CYCLES == 0) ? ST_RUN : ST_HOLD;
                end
                ST_HOLD: begin
                    r_hold_cnt <= w_hold_next;
                    if (w_hold_next == '0) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Register-file write port, valid the cycle after the commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_we <= w_commit && head_reg_write_en_in;
            if (w_commit) begin
                r_rf_addr <= head_reg_write_addr_in;
                r_rf_data <= head_reg_write_data_in;
            end
        end
    end

    // Exception request: latch head fields at the flush and pulse exc_en for one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exc_en   <= 1'b0;
            r_exc_type <= '0;
            r_exc_epc  <= '0;
            r_exc_bd   <= 1'b0;
        end else begin
            r_exc_en <= w_exc_fire;
            if (w_exc_fire) begin
                r_exc_type <= head_exception_type_in;
                r_exc_epc  <= calc_epc(head_pc_in, head_is_delayslot_in);
                r_exc_bd   <= head_is_delayslot_in;
            end
        end
    end

    rob_commit_ctrl_head_tracker #(
        .ADDR_W (ROB_ADDR_WIDTH)
    ) u_head_tracker (
        .clk            (clk),
        .rst            (rst),
        .i_inc          (w_commit),
        .i_clr          (r_state == ST_FLUSH),
        .o_head_ptr     (w_head_ptr),
        .o_commit_count (w_commit_count)
    );

    assign commit_en        = w_commit;
    assign erase_en         = w_erase;
    assign erase_from_addr  = w_erase_from;
    assign rf_write_en      = r_rf_we;
    assign rf_write_addr    = r_rf_addr;
    assign rf_write_data    = r_rf_data;
    assign exc_en           = r_exc_en;
    assign exc_type         = r_exc_type;
    assign exc_epc          = r_exc_epc;
    assign exc_is_delayslot = r_exc_bd;
    assign busy             = (r_state != ST_RUN);
    assign commit_count     = w_commit_count;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl with hand-computed expectations.
module tb_rob_commit_ctrl;

    localparam int AW = 4;
    localparam int EW = 8;
    localparam int HC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          can_commit;
    logic          head_reg_write_en_in;
    logic [4:0]    head_reg_write_addr_in;
    logic [31:0]   head_reg_write_data_in;
    logic [EW-1:0] head_exception_type_in;
    logic          head_is_delayslot_in;
    logic [31:0]   head_pc_in;
    logic          stall;
    logic          br_flush_en;
    logic [AW-1:0] br_flush_from_addr;
    logic          commit_en;
    logic          erase_en;
    logic [AW-1:0] erase_from_addr;
    logic          rf_write_en;
    logic [4:0]    rf_write_addr;
    logic [31:0]   rf_write_data;
    logic          exc_en;
    logic [EW-1:0] exc_type;
    logic [31:0]   exc_epc;
    logic          exc_is_delayslot;
    logic          busy;
    logic [31:0]   commit_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_head;
    int exp_count;

    always #5 clk = ~clk;

    rob_commit_ctrl #(
        .ROB_ADDR_WIDTH (AW),
        .EXC_TYPE_WIDTH (EW),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .can_commit             (can_commit),
        .head_reg_write_en_in   (head_reg_write_en_in),
        .head_reg_write_addr_in (head_reg_write_addr_in),
        .head_reg_write_data_in (head_reg_write_data_in),
        .head_exception_type_in (head_exception_type_in),
        .head_is_delayslot_in   (head_is_delayslot_in),
        .head_pc_in             (head_pc_in),
        .stall                  (stall),
        .br_flush_en            (br_flush_en),
        .br_flush_from_addr     (br_flush_from_addr),
        .commit_en              (commit_en),
        .erase_en               (erase_en),
        .erase_from_addr        (erase_from_addr),
        .rf_write_en            (rf_write_en),
        .rf_write_addr          (rf_write_addr),
        .rf_write_data          (rf_write_data),
        .exc_en                 (exc_en),
        .exc_type               (exc_type),
        .exc_epc                (exc_epc),
        .exc_is_delayslot       (exc_is_delayslot),
        .busy                   (busy),
        .commit_count           (commit_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        can_commit             = 1'b0;
        head_reg_write_en_in   = 1'b0;
        head_reg_write_addr_in = '0;
        head_reg_write_data_in = '0;
        head_exception_type_in = '0;
        head_is_delayslot_in   = 1'b0;
        head_pc_in             = '0;
        stall                  = 1'b0;
        br_flush_en            = 1'b0;
        br_flush_from_addr     = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_commit_en"}, 32'(commit_en), 32'd0);
        check({tag, "_erase_en"}, 32'(erase_en), 32'd0);
        check({tag, "_erase_from"}, 32'(erase_from_addr), 32'd0);
        check({tag, "_rf_we"}, 32'(rf_write_en), 32'd0);
        check({tag, "_rf_addr"}, 32'(rf_write_addr), 32'd0);
        check({tag, "_rf_data"}, rf_write_data, 32'd0);
        check({tag, "_exc_en"}, 32'(exc_en), 32'd0);
        check({tag, "_exc_type"}, 32'(exc_type), 32'd0);
        check({tag, "_exc_epc"}, exc_epc, 32'd0);
        check({tag, "_exc_bd"}, 32'(exc_is_delayslot), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_count"}, commit_count, 32'd0);
        check({tag, "_head"}, 32'(dut.w_head_ptr), 32'd0);
    endtask

    // A mispredict may never erase the entry being committed in the same cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            assert (!(commit_en && br_flush_en && (br_flush_from_addr == dut.w_head_ptr)))
                else $error("illegal branch erase of the committing head entry");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        // Inputs requesting activity while in reset must not reach the outputs.
        can_commit  = 1'b1;
        br_flush_en = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        clear_inputs();
        rst = 1'b1;
        exp_head  = 0;
        exp_count = 0;

        // Three back-to-back commits.
        for (int i = 0; i < 3; i++) begin
            can_commit             = 1'b1;
            head_reg_write_en_in   = 1'b1;
            head_reg_write_addr_in = 5'(i + 1);
            head_reg_write_data_in = 32'h100 + 32'(i);
            head_pc_in             = 32'hbfc00000 + 32'(4 * i);
            #1;
            check("c3_commit_en", 32'(commit_en), 32'd1);
            check("c3_erase_en", 32'(erase_en), 32'd0);
            tick();
            exp_head++;
            exp_count++;
            check("c3_rf_we", 32'(rf_write_en), 32'd1);
            check("c3_rf_addr", 32'(rf_write_addr), 32'(i + 1));
            check("c3_rf_data", rf_write_data, 32'h100 + 32'(i));
        end
        clear_inputs();
        #1;
        check("c3_idle_commit", 32'(commit_en), 32'd0);
        check("c3_count", commit_count, 32'd3);
        check("c3_head", 32'(dut.w_head_ptr), 32'd3);
        tick();
        check("c3_rf_we_off", 32'(rf_write_en), 32'd0);

        // Delay-slot exception at the head.
        can_commit             = 1'b1;
        head_exception_type_in = 8'h04;
        head_pc_in             = 32'hbfc00010;
        head_is_delayslot_in   = 1'b1;
        #1;
        check("exc_commit_en", 32'(commit_en), 32'd0);
        check("exc_erase_en", 32'(erase_en), 32'd1);
        check("exc_erase_from", 32'(erase_from_addr), 32'd3);
        check("exc_en_early", 32'(exc_en), 32'd0);
        tick();
        // FLUSH: new head and a branch request must both be ignored.
        head_exception_type_in = '0;
        head_is_delayslot_in   = 1'b0;
        br_flush_en            = 1'b1;
        br_flush_from_addr     = 4'd2;
        #1;
        check("flush_exc_en", 32'(exc_en), 32'd1);
        check("flush_exc_type", 32'(exc_type), 32'h04);
        check("flush_epc", exc_epc, 32'hbfc0000c);
        check("flush_bd", 32'(exc_is_delayslot), 32'd1);
        check("flush_busy", 32'(busy), 32'd1);
        check("flush_commit_en", 32'(commit_en), 32'd0);
        check("flush_erase_en", 32'(erase_en), 32'd0);
        for (int h = 0; h < HC; h++) begin
            tick();
            check("hold_exc_en", 32'(exc_en), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_commit_en", 32'(commit_en), 32'd0);
            check("hold_erase_en", 32'(erase_en), 32'd0);
            check("hold_head", 32'(dut.w_head_ptr), 32'd0);
        end
        exp_head = 0;
        tick();
        // Back in RUN: commit and mispredict erase in the same cycle.
        check("run_busy", 32'(busy), 32'd0);
        check("br_commit_en", 32'(commit_en), 32'd1);
        check("br_erase_en", 32'(erase_en), 32'd1);
        check("br_erase_from", 32'(erase_from_addr), 32'd2);
        check("br_count_before", commit_count, 32'd3);
        tick();
        exp_head++;
        exp_count++;
        check("br_count", commit_count, 32'(exp_count));
        check("br_head", 32'(dut.w_head_ptr), 32'(exp_head));
        clear_inputs();

        // Exception and mispredict together: exception wins.
        can_commit             = 1'b1;
        head_exception_type_in = 8'h0c;
        head_pc_in             = 32'h80000100;
        head_is_delayslot_in   = 1'b0;
        br_flush_en            = 1'b1;
        br_flush_from_addr     = 4'd5;
        #1;
        check("race_erase_en", 32'(erase_en), 32'd1);
        check("race_erase_from", 32'(erase_from_addr), 32'd1);
        check("race_commit_en", 32'(commit_en), 32'd0);
        tick();
        clear_inputs();
        check("race_exc_en", 32'(exc_en), 32'd1);
        check("race_exc_type", 32'(exc_type), 32'h0c);
        check("race_epc", exc_epc, 32'h80000100);
        check("race_bd", 32'(exc_is_delayslot), 32'd0);
        for (int h = 0; h <= HC; h++) tick();
        exp_head = 0;
        check("race_busy_done", 32'(busy), 32'd0);
        check("race_head", 32'(dut.w_head_ptr), 32'd0);
        check("race_count", commit_count, 32'(exp_count));

        // Stall holds off commits and a pending head exception.
        can_commit             = 1'b1;
        stall                  = 1'b1;
        head_exception_type_in = 8'h20;
        #1;
        check("stall_exc_erase", 32'(erase_en), 32'd0);
        tick();
        check("stall_exc_busy", 32'(busy), 32'd0);
        check("stall_exc_en", 32'(exc_en), 32'd0);
        head_exception_type_in = '0;
        head_reg_write_en_in   = 1'b1;
        head_reg_write_addr_in = 5'd7;
        head_reg_write_data_in = 32'hdeadbeef;
        for (int s = 0; s < 4; s++) begin
            #1;
            check("stall_commit_en", 32'(commit_en), 32'd0);
            tick();
            check("stall_rf_we", 32'(rf_write_en), 32'd0);
        end
        check("stall_count", commit_count, 32'(exp_count));
        stall = 1'b0;
        #1;
        check("unstall_commit_en", 32'(commit_en), 32'd1);
        tick();
        exp_head++;
        exp_count++;
        check("unstall_rf_we", 32'(rf_write_en), 32'd1);
        check("unstall_rf_addr", 32'(rf_write_addr), 32'd7);
        check("unstall_rf_data", rf_write_data, 32'hdeadbeef);
        check("unstall_count", commit_count, 32'(exp_count));

        // 17 commits: head wraps through 15 -> 0; rf_write_en follows the head flag.
        for (int k = 0; k < 17; k++) begin
            can_commit             = 1'b1;
            head_reg_write_en_in   = 1'(k % 2);
            head_reg_write_addr_in = 5'(k);
            head_reg_write_data_in = 32'(k * 3);
            #1;
            check("wrap_commit_en", 32'(commit_en), 32'd1);
            tick();
            exp_head  = (exp_head + 1) % 16;
            exp_count++;
            check("wrap_head", 32'(dut.w_head_ptr), 32'(exp_head));
            check("wrap_rf_we", 32'(rf_write_en), 32'(k % 2));
            if ((k % 2) == 1) check("wrap_rf_data", rf_write_data, 32'(k * 3));
        end
        check("wrap_count", commit_count, 32'(exp_count));
        clear_inputs();

        // Reset asserted during HOLD.
        can_commit             = 1'b1;
        head_exception_type_in = 8'h10;
        head_pc_in             = 32'h00000100;
        #1;
        check("rh_erase_en", 32'(erase_en), 32'd1);
        tick();
        clear_inputs();
        tick();
        check("rh_busy_hold", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        check_all_zero("rh");
        rst = 1'b1;
        can_commit             = 1'b1;
        head_reg_write_en_in   = 1'b1;
        head_reg_write_addr_in = 5'd31;
        head_reg_write_data_in = 32'h12345678;
        #1;
        check("post_commit_en", 32'(commit_en), 32'd1);
        tick();
        clear_inputs();
        check("post_rf_data", rf_write_data, 32'h12345678);
        check("post_count", commit_count, 32'd1);
        check("post_head", 32'(dut.w_head_ptr), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
